// File: rtl/pipe_state_dump.sv
// Streams a snapshot of CPU state (optional PC header, register file, low data memory) on a valid/ready port.
// Define PIPE_DUMP_PC_EN to prepend the captured PC as a header word at index 7'h7F.

// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start_i or the auto-trigger cycle
// HDR   | loading the captured PC header word
// REG   | loading register-file words, idx = register number
// MEM   | loading data-memory bytes, idx = byte address
// FIN   | last word loaded, waiting for its handshake
module pipe_state_dump #(
    parameter int NUM_REGS   = 32,
    parameter int NUM_MEM    = 32,
    parameter int AUTO_CYCLE = 17
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] pc_i,
    output logic [4:0]  rf_addr_o,
    input  logic [31:0] rf_data_i,
    output logic [6:0]  dm_addr_o,
    input  logic [7:0]  dm_data_i,
    output logic [31:0] dout_o,
    output logic [6:0]  dout_idx_o,
    output logic        dout_valid_o,
    input  logic        dout_ready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] cycle_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_REG,
        S_MEM,
        S_FIN
    } state_t;

    localparam logic [6:0]  LAST_REG = 7'(NUM_REGS - 1);
    localparam logic [6:0]  LAST_MEM = 7'(NUM_MEM - 1);
    localparam logic [6:0]  MEM_BASE = 7'(NUM_REGS);
    localparam logic [31:0] AUTO_VAL = 32'(AUTO_CYCLE);

    state_t     state;
    logic [6:0] idx;
    logic       auto_hit;
    logic       start_req;
    logic       load;

`ifdef PIPE_DUMP_PC_EN
    logic [31:0] pc_q;
`else
    logic unused_pc;
    assign unused_pc = ^pc_i;
`endif

    assign auto_hit  = (AUTO_CYCLE != 0) && (cycle_cnt_o == AUTO_VAL);
    assign start_req = start_i || auto_hit;
    assign load      = !dout_valid_o || dout_ready_i;

    // Read addresses decode only registered state, so they move on clock edges alone.
    assign rf_addr_o = (state == S_REG) ? idx[4:0] : 5'd0;
    assign dm_addr_o = (state == S_MEM) ? idx : 7'd0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cycle_cnt_o <= 32'd0;
        end else if (cycle_cnt_o != 32'hFFFF_FFFF) begin
            cycle_cnt_o <= cycle_cnt_o + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= S_IDLE;
            idx          <= 7'd0;
            dout_o       <= 32'd0;
            dout_idx_o   <= 7'd0;
            dout_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
`ifdef PIPE_DUMP_PC_EN
            pc_q         <= 32'd0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_req) begin
                        idx    <= 7'd0;
                        busy_o <= 1'b1;
`ifdef PIPE_DUMP_PC_EN
                        pc_q   <= pc_i;
                        state  <= S_HDR;
`else
                        state  <= S_REG;
`endif
                    end
                end
`ifdef PIPE_DUMP_PC_EN
                S_HDR: begin
                    // The header does not consume an index: r0 still follows at idx 0.
                    if (load) begin
                        dout_o       <= pc_q;
                        dout_idx_o   <= 7'h7F;
                        dout_valid_o <= 1'b1;
                        state        <= S_REG;
                    end
                end
`endif
                S_REG: begin
                    if (load) begin
                        dout_o       <= rf_data_i;
                        dout_idx_o   <= idx;
                        dout_valid_o <= 1'b1;
                        if (idx == LAST_REG) begin
                            idx   <= 7'd0;
                            state <= S_MEM;
                        end else begin
                            idx <= idx + 7'd1;
                        end
                    end
                end
                S_MEM: begin
                    if (load) begin
                        dout_o       <= {24'd0, dm_data_i};
                        dout_idx_o   <= MEM_BASE + idx;
                        dout_valid_o <= 1'b1;
                        idx          <= idx + 7'd1;
                        if (idx == LAST_MEM) begin
                            state <= S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    if (dout_valid_o && dout_ready_i) begin
                        dout_valid_o <= 1'b0;
                        busy_o       <= 1'b0;
                        done_o       <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
